// File: rtl/encoder_mux.sv
// encoder_mux: registered 7-to-3 priority encoder alongside a registered
// 3-input bit multiplexer. The two paths share only clk, rst_n and en.
module encoder_mux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] x,
  output logic [2:0] y,
  input  logic [2:0] ym,
  input  logic [1:0] sm,
  output logic       zm
);

  localparam int unsigned XW = 7;
  localparam int unsigned YW = 3;

  logic [YW-1:0] y_next;
  logic          zm_next;

  // Priority encoder: one-based index of the highest set bit, 0 when x is empty
  always_comb begin
    y_next = '0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (x[i]) begin
        y_next = YW'(i + 1);
      end
    end
  end

  // Bit mux: select 3 is a defined constant 0 so zm never goes unknown
  always_comb begin
    zm_next = 1'b0;
    case (sm)
      2'd0:    zm_next = ym[0];
      2'd1:    zm_next = ym[1];
      2'd2:    zm_next = ym[2];
      default: zm_next = 1'b0;
    endcase
  end

  // Output registers: clear asynchronously, capture only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y  <= '0;
      zm <= 1'b0;
    end else if (en) begin
      y  <= y_next;
      zm <= zm_next;
    end
  end

endmodule

// File: tb/tb_encoder_mux.sv
// Directed self-checking bench for encoder_mux.
module tb_encoder_mux;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] x;
  logic [2:0] y;
  logic [2:0] ym;
  logic [1:0] sm;
  logic       zm;

  int checks;
  int failures;

  encoder_mux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .x     (x),
    .y     (y),
    .ym    (ym),
    .sm    (sm),
    .zm    (zm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] enc_x   [6];
  logic [2:0] enc_exp [6];
  logic [6:0] sweep_x [5];
  logic [2:0] sweep_y [5];
  logic [2:0] tog_ym  [4];
  logic [1:0] tog_sm  [4];

  initial begin
    checks   = 0;
    failures = 0;

    enc_x   = '{7'b0000000, 7'b0100001, 7'b1000010, 7'b0000100, 7'b0000001, 7'b0010000};
    enc_exp = '{3'd0, 3'd6, 3'd7, 3'd3, 3'd1, 3'd5};
    sweep_x = '{7'b0000000, 7'b1000000, 7'b0000010, 7'b0101010, 7'b0001000};
    sweep_y = '{3'd0, 3'd7, 3'd2, 3'd6, 3'd4};
    tog_ym  = '{3'b000, 3'b111, 3'b010, 3'b101};
    tog_sm  = '{2'd0, 2'd1, 2'd2, 2'd3};

    // Reset held from time zero with active inputs
    rst_n = 1'b0;
    en    = 1'b1;
    x     = 7'b1111111;
    ym    = 3'b111;
    sm    = 2'd2;
    #3;
    check("reset_y", 8'(y), 8'd0);
    check("reset_zm", 8'(zm), 8'd0);
    rst_n = 1'b1;
    step();
    check("release_y", 8'(y), 8'd7);
    check("release_zm", 8'(zm), 8'd1);

    // Mid-cycle reset pulse clears outputs without an edge
    #3 rst_n = 1'b0;
    #1;
    check("midreset_y", 8'(y), 8'd0);
    check("midreset_zm", 8'(zm), 8'd0);
    #2 rst_n = 1'b1;
    step();
    check("rerelease_y", 8'(y), 8'd7);
    check("rerelease_zm", 8'(zm), 8'd1);

    // Encoder sweep, one-edge latency each
    for (int i = 0; i < 6; i++) begin
      x = enc_x[i];
      #1;
      check("enc_before_edge", 8'(y), (i == 0) ? 8'd7 : 8'(enc_exp[i-1]));
      step();
      check("enc_sweep", 8'(y), 8'(enc_exp[i]));
    end

    // Priority masking
    x = 7'b0001111;
    step();
    check("mask_0001111", 8'(y), 8'd4);
    x = 7'b0011111;
    step();
    check("mask_0011111", 8'(y), 8'd5);

    // Explicit mux example ym=101
    ym = 3'b101;
    sm = 2'd0; step(); check("mux_101_s0", 8'(zm), 8'd1);
    sm = 2'd1; step(); check("mux_101_s1", 8'(zm), 8'd0);
    sm = 2'd2; step(); check("mux_101_s2", 8'(zm), 8'd1);
    sm = 2'd3; step(); check("mux_101_s3", 8'(zm), 8'd0);

    // Full mux sweep; x held so y must stay 5
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < 4; s++) begin
        logic [2:0] vb;
        vb = 3'(v);
        ym = vb;
        sm = 2'(s);
        step();
        check("mux_sweep", 8'(zm), (s == 3) ? 8'd0 : 8'(vb[s]));
        check("mux_sweep_y", 8'(y), 8'd5);
      end
    end

    // Enable hold
    x  = 7'b0000100;
    ym = 3'b010;
    sm = 2'd1;
    step();
    check("hold_load_y", 8'(y), 8'd3);
    check("hold_load_zm", 8'(zm), 8'd1);
    en = 1'b0;
    x  = 7'b1000000;
    sm = 2'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("hold_y", 8'(y), 8'd3);
      check("hold_zm", 8'(zm), 8'd1);
    end
    en = 1'b1;
    step();
    check("hold_release_y", 8'(y), 8'd7);
    check("hold_release_zm", 8'(zm), 8'd0);

    // Path independence: mux activity must not disturb y
    x = 7'b0010000;
    step();
    check("indep_x_load", 8'(y), 8'd5);
    for (int i = 0; i < 4; i++) begin
      ym = tog_ym[i];
      sm = tog_sm[i];
      step();
      check("indep_y", 8'(y), 8'd5);
    end

    // Path independence: encoder activity must not disturb zm
    ym = 3'b101;
    sm = 2'd2;
    step();
    check("indep_zm_load", 8'(zm), 8'd1);
    for (int i = 0; i < 5; i++) begin
      x = sweep_x[i];
      step();
      check("indep_zm", 8'(zm), 8'd1);
      check("indep_sweep_y", 8'(y), 8'(sweep_y[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
